// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel streams of DW bits each.
// master drives data/valid/last and receives ready; slave is the reverse.
interface axis_uart_tx_arbiter_if #(
  parameter int DW    = 256,
  parameter int LANES = 1
);
  logic [LANES*DW-1:0] TDATA;
  logic [LANES-1:0]    TVALID;
  logic [LANES-1:0]    TLAST;
  logic [LANES-1:0]    TREADY;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, burst-granular arbiter sharing one UART TX bridge among N_REQ AXIS
// requesters, with a single registered output stage toward the bridge.
//
// state | meaning
// IDLE  | no owner; pick next valid requester after last_grant (1-cycle decision)
// GRANT | owner GRANT_ID may push words until TLAST or MAX_BURST words
module axis_uart_tx_arbiter #(
  parameter int N_BYTES   = 32,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  axis_uart_tx_arbiter_if.slave  S_AXIS,
  axis_uart_tx_arbiter_if.master M_AXIS,
  output logic [GW-1:0]          GRANT_ID,
  output logic                   BUSY
);
  localparam int DW = N_BYTES * 8;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT = '1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     pick;
  logic              pick_vld;
  logic [CW-1:0]     burst_cnt;
  logic [N_REQ-1:0]  ready;
  logic              slot_free;
  logic              accept;
  logic              burst_done;
  logic              out_vld;
  logic              out_last;
  logic [DW-1:0]     out_data;
  int                idx;

  // Scan last_grant+1 .. last_grant+N_REQ; descending loop so the nearest wins.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (S_AXIS.TVALID[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign slot_free  = !out_vld || M_AXIS.TREADY;
  assign accept     = S_AXIS.TVALID[GRANT_ID] && ready[GRANT_ID];
  assign burst_done = accept && (S_AXIS.TLAST[GRANT_ID] ||
                      ((MAX_BURST != 0) && (int'(burst_cnt) + 1 == MAX_BURST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = GRANT;
      end
      GRANT: begin
        ready[GRANT_ID] = slot_free;
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign S_AXIS.TREADY = ready;

  // GRANT_ID resets to 0 while the pointer resets to N_REQ-1 so port 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GW'(N_REQ - 1);
      GRANT_ID   <= '0;
      burst_cnt  <= '0;
    end else if (state == IDLE && pick_vld) begin
      last_grant <= pick;
      GRANT_ID   <= pick;
      burst_cnt  <= '0;
    end else if (accept && burst_cnt != CNT_SAT) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_last <= S_AXIS.TLAST[GRANT_ID];
      out_data <= S_AXIS.TDATA[int'(GRANT_ID)*DW +: DW];
    end else if (M_AXIS.TREADY) begin
      out_vld <= 1'b0;
    end
  end

  assign M_AXIS.TDATA  = out_data;
  assign M_AXIS.TVALID = out_vld;
  assign M_AXIS.TLAST  = out_last;
  assign BUSY          = (state == GRANT) || out_vld;
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: directed bursts with hand-ordered
// expected output, backpressure and reset cases, then random per-port traffic.
module tb_axis_uart_tx_arbiter;
  localparam int N_BYTES   = 32;
  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 16;
  localparam int DW        = N_BYTES * 8;
  localparam int GW        = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axis_uart_tx_arbiter_if #(.DW(DW), .LANES(N_REQ)) s_if ();
  axis_uart_tx_arbiter_if #(.DW(DW), .LANES(1))     m_if ();
  logic [GW-1:0] grant_id;
  logic          busy;

  axis_uart_tx_arbiter #(.N_BYTES(N_BYTES), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .S_AXIS(s_if), .M_AXIS(m_if),
    .GRANT_ID(grant_id), .BUSY(busy)
  );

  logic [DW-1:0] drv_data  [N_REQ];
  logic          drv_valid [N_REQ];
  logic          drv_last  [N_REQ];

  always_comb begin
    s_if.TDATA  = '0;
    s_if.TVALID = '0;
    s_if.TLAST  = '0;
    for (int p = 0; p < N_REQ; p++) begin
      s_if.TDATA[p*DW +: DW] = drv_data[p];
      s_if.TVALID[p]         = drv_valid[p];
      s_if.TLAST[p]          = drv_last[p];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_mode = 1'b0;
  bit abort_drv = 1'b0;
  int rdy_mode  = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled

  typedef struct { logic [DW-1:0] data; int at; } exp_t;
  exp_t          exp_q [$];
  logic [DW-1:0] port_q [N_REQ][$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word(int p, int s);
    logic [DW-1:0] w;
    w            = '0;
    w[DW-1 -: 8] = 8'(p);
    w[DW-9 -: 24] = 24'(s);
    w[127:96]    = 32'(s) * 32'h9E37_79B9;
    w[7:0]       = 8'(p);
    return w;
  endfunction

  function automatic int qsum();
    int n = 0;
    for (int p = 0; p < N_REQ; p++) n += port_q[p].size();
    return n;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(int p, int s, int at);
    exp_t e;
    e.data = word(p, s);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic send_burst(int p, int first, int len, int gap);
    int t;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (abort_drv) return;
      drv_data[p]  = word(p, first + i);
      drv_valid[p] = 1'b1;
      drv_last[p]  = (i == len - 1);
      if (rand_mode) port_q[p].push_back(word(p, first + i));
      t = 0;
      #1;
      while (!s_if.TREADY[p]) begin
        if (abort_drv) return;
        t++;
        if (t > 3000) begin
          n_checks++;
          n_fail++;
          $display("FAIL drv_timeout port %0d: actual not accepted required accepted", p);
          drv_valid[p] = 1'b0;
          return;
        end
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    drv_valid[p] = 1'b0;
    drv_last[p]  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rand_port(int p);
    int sent = 0;
    int len;
    while (sent < 2500) begin
      len = $urandom_range(1, 40);
      if (sent + len > 2500) len = 2500 - sent;
      send_burst(p, sent, len, $urandom_range(0, 3));
      sent += len;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() + qsum()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", DW'(exp_q.size() + qsum()), '0);
  endtask

  // Output-side ready generator
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph  = 0;
    m_if.TREADY = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       m_if.TREADY = pat[ph % 4];
        2:       m_if.TREADY = 1'($urandom_range(0, 1));
        3:       m_if.TREADY = 1'b0;
        default: m_if.TREADY = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks invariants
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            bcnt  [N_REQ];
    int            waitb [N_REQ];
    exp_t          e;
    int            p;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin bcnt[i] = 0; waitb[i] = 0; end
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        prev_stall = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin bcnt[i] = 0; waitb[i] = 0; end
      end else begin
        chk("tready_onehot0", DW'($onehot0(s_if.TREADY)), DW'(1));
        if (prev_stall) begin
          chk("stall_hold_valid", DW'(m_if.TVALID), DW'(1));
          chk("stall_hold_data", m_if.TDATA, prev_data);
        end
        if (m_if.TVALID && !m_if.TREADY)
          chk("stall_blocks_input", DW'(|s_if.TREADY), '0);
        if (m_if.TVALID && m_if.TREADY) begin
          if (rand_mode) begin
            p = int'(m_if.TDATA[7:0]);
            if (p >= N_REQ || port_q[p].size() == 0) begin
              chk("unexpected_rand_word", m_if.TDATA, '0);
            end else begin
              chk("rand_port_order", m_if.TDATA, port_q[p].pop_front());
            end
          end else if (exp_q.size() == 0) begin
            chk("unexpected_word", m_if.TDATA, '0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_if.TDATA, e.data);
            if (e.at >= 0) chk("out_cycle", DW'(cyc), DW'(e.at));
          end
        end
        for (int q = 0; q < N_REQ; q++) begin
          if (s_if.TVALID[q] && s_if.TREADY[q]) begin
            waitb[q] = 0;
            bcnt[q]++;
            if (s_if.TLAST[q] || bcnt[q] == MAX_BURST) begin
              bcnt[q] = 0;
              for (int w = 0; w < N_REQ; w++) begin
                if (w != q && s_if.TVALID[w]) begin
                  waitb[w]++;
                  chk("fair_wait", DW'(waitb[w] <= N_REQ - 1), DW'(1));
                end
              end
            end
          end
        end
        for (int q = 0; q < N_REQ; q++) if (!s_if.TVALID[q]) waitb[q] = 0;
        prev_stall = m_if.TVALID && !m_if.TREADY;
        prev_data  = m_if.TDATA;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < N_REQ; i++) begin
      drv_data[i] = '0; drv_valid[i] = 1'b0; drv_last[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", DW'(m_if.TVALID), '0);
    chk("rst_m_tdata", m_if.TDATA, '0);
    chk("rst_s_tready", DW'(s_if.TREADY), '0);
    chk("rst_grant_id", DW'(grant_id), '0);
    chk("rst_busy", DW'(busy), '0);
    reset = 1'b0;

    // Single port 0, three words on cycles 2,3,4 after TVALID
    @(negedge clk);
    c = cyc;
    push(0, 0, c + 3); push(0, 1, c + 4); push(0, 2, c + 5);
    send_burst(0, 0, 3, 0);
    drain();
    chk("t1_grant_id", DW'(grant_id), '0);
    chk("t1_idle_busy", DW'(busy), '0);
    chk("t1_idle_tready", DW'(s_if.TREADY), '0);

    // Ports 1 and 2 together after reset, then wrap to port 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(1, 0, -1); push(1, 1, -1); push(2, 0, -1); push(2, 1, -1);
    fork
      send_burst(1, 0, 2, 0);
      send_burst(2, 0, 2, 0);
    join
    drain();
    push(0, 10, -1); push(1, 10, -1);
    fork
      send_burst(0, 10, 1, 0);
      send_burst(1, 10, 1, 0);
    join
    drain();

    // MAX_BURST split: P3 x16, P0, P3 x16, P0, P3 x8
    for (int i = 0; i < 16; i++) push(3, i, -1);
    push(0, 100, -1); push(0, 101, -1);
    for (int i = 16; i < 32; i++) push(3, i, -1);
    push(0, 102, -1); push(0, 103, -1);
    for (int i = 32; i < 40; i++) push(3, i, -1);
    fork
      send_burst(3, 0, 40, 0);
      begin
        send_burst(0, 100, 2, 0);
        send_burst(0, 102, 2, 0);
      end
    join
    drain();

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) push(0, 200 + i, -1);
    send_burst(0, 200, 6, 0);
    drain();
    rdy_mode = 0;

    // Reset with a word held in the output register
    rdy_mode = 3;
    fork
      send_burst(0, 300, 4, 0);
    join_none
    repeat (5) @(negedge clk);
    chk("t5_reg_full", DW'(m_if.TVALID), DW'(1));
    #2;
    reset     = 1'b1;
    abort_drv = 1'b1;
    #1;
    chk("t5_rst_m_tvalid", DW'(m_if.TVALID), '0);
    chk("t5_rst_s_tready", DW'(s_if.TREADY), '0);
    chk("t5_rst_busy", DW'(busy), '0);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin drv_valid[i] = 1'b0; drv_last[i] = 1'b0; end
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b0;
    abort_drv = 1'b0;
    rdy_mode  = 0;
    push(0, 400, -1); push(1, 400, -1); push(3, 400, -1);
    fork
      send_burst(0, 400, 1, 0);
      send_burst(1, 400, 1, 0);
      send_burst(3, 400, 1, 0);
    join
    drain();

    // Random traffic, 4 x 2500 words, random output ready
    rand_mode = 1'b1;
    rdy_mode  = 2;
    fork
      rand_port(0);
      rand_port(1);
      rand_port(2);
      rand_port(3);
    join
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
